// File: rtl/pc_reg.sv
// Program-counter register stage: latches the next PC from mx_pc, fetches from
// instruction memory over req/ack, and stops on halt or on an ack timeout.
// Optional fetch/jump performance counters are enabled by defining PC_PERF_CNT_EN.
module pc_reg #(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_PC    = '0,
    parameter int unsigned      INC         = 1,
    parameter int unsigned      ACK_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_MXPC,
    input  logic             W_PC,
    input  logic             stall,
    input  logic             halt,
    input  logic             imem_ack,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    output logic             ir_valid,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus1,
    output logic             halted,
    output logic             fault,
`ifdef PC_PERF_CNT_EN
    input  logic             jump,
    output logic [31:0]      fetch_cnt,
    output logic [31:0]      jump_cnt,
`endif
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_HALT  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    localparam int unsigned CW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(ACK_TIMEOUT - 1);

    state_t        state;
    logic [CW-1:0] tmo_cnt;

    assign imem_addr = pc;
    assign pc_plus1  = pc + WIDTH'(INC);
    assign state_dbg = state;

    // Handshake: imem_req stays high for every FETCH cycle with imem_addr stable;
    // the memory completes the transfer by raising imem_ack in any such cycle, and
    // the fetch counts as accepted at that rising edge. Acks outside FETCH are ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            imem_req <= 1'b0;
            ir_valid <= 1'b0;
            halted   <= 1'b0;
            fault    <= 1'b0;
            tmo_cnt  <= '0;
        end else begin
            ir_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (halt) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                        tmo_cnt  <= '0;
                    end
                end
                S_FETCH: begin
                    // An ack in the last allowed cycle still beats the timeout.
                    if (imem_ack) begin
                        state    <= S_EXEC;
                        ir_valid <= 1'b1;
                        imem_req <= 1'b0;
                        tmo_cnt  <= '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state    <= S_FAULT;
                        fault    <= 1'b1;
                        imem_req <= 1'b0;
                        tmo_cnt  <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_EXEC: begin
                    if (halt) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else if (W_PC && !stall) begin
                        pc       <= in_MXPC;
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                        tmo_cnt  <= '0;
                    end
                end
                S_HALT, S_FAULT: begin
                    imem_req <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_PERF_CNT_EN
    logic jump_take;
    assign jump_take = (state == S_EXEC) && !halt && W_PC && !stall && jump;

    // ir_valid is only ever high in EXEC, so both counters freeze once HALT/FAULT is reached.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt <= '0;
            jump_cnt  <= '0;
        end else begin
            if (ir_valid && fetch_cnt != 32'hFFFF_FFFF) fetch_cnt <= fetch_cnt + 32'd1;
            if (jump_take && jump_cnt != 32'hFFFF_FFFF) jump_cnt <= jump_cnt + 32'd1;
        end
    end
`endif

endmodule
